// File: rtl/rf_writeback_sequencer_if.sv
// Writeback bus between the last pipeline stage, the data memory read port
// and the register-file write ports. The sequencer takes the slave modport.
interface rf_writeback_sequencer_if #(
  parameter int DATA_W = 16
);
  logic              wb_valid;
  logic              wb_ready;
  logic              wb_lm;
  logic              wb_wr_en;
  logic [2:0]        wb_dest;
  logic [DATA_W-1:0] wb_data;
  logic [7:0]        wb_mask;
  logic [DATA_W-1:0] wb_base;
  logic              wb_pc_en;
  logic [DATA_W-1:0] wb_pc;

  logic              mem_rd_en;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;

  logic [2:0]        A3;
  logic [DATA_W-1:0] RF3;
  logic              rf3_wr_en;
  logic [DATA_W-1:0] RF4;
  logic              rf4_wr_en;

  modport master (
    output wb_valid, wb_lm, wb_wr_en, wb_dest, wb_data, wb_mask, wb_base,
           wb_pc_en, wb_pc, mem_rdata,
    input  wb_ready, mem_rd_en, mem_addr, A3, RF3, rf3_wr_en, RF4, rf4_wr_en
  );

  modport slave (
    input  wb_valid, wb_lm, wb_wr_en, wb_dest, wb_data, wb_mask, wb_base,
           wb_pc_en, wb_pc, mem_rdata,
    output wb_ready, mem_rd_en, mem_addr, A3, RF3, rf3_wr_en, RF4, rf4_wr_en
  );
endinterface

// File: rtl/rf_writeback_sequencer.sv
// Write-side driver of the 8x16 register file. Single writes pass through
// with one cycle of latency; load-multiple transactions are serialised into
// one memory read per selected register, each read landing as an rf3 write
// two cycles after it was issued.
//
// state    | meaning
// IDLE     | ready for a transaction; single writes complete from here
// LM_ISSUE | issuing one memory read per cycle for remaining mask bits
// LM_DRAIN | reads done, waiting for the last read data to be written
module rf_writeback_sequencer #(
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 1
) (
  input logic                    clk,
  input logic                    reset,
  rf_writeback_sequencer_if.slave bus
);

  // The read-to-write pipeline below is hard-wired for single-cycle memory.
  generate
    if (MEM_LAT != 1) begin : g_bad_mem_lat
      $error("rf_writeback_sequencer: MEM_LAT must be 1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, LM_ISSUE, LM_DRAIN} state_t;

  state_t            state;
  logic [7:0]        mask;
  logic [DATA_W-1:0] base;
  logic [DATA_W-1:0] offset;
  logic [2:0]        tag;
  logic              pend;
  logic [2:0]        pend_tag;

  logic              accept;
  logic              lm_go;
  logic              single_wr;
  logic [7:0]        mask_clr;
  logic [7:0]        wb_mask_clr;

  // Index of the lowest set bit; registers are loaded R0 first.
  function automatic logic [2:0] low_idx(input logic [7:0] m);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) idx = i[2:0];
    end
    return idx;
  endfunction

  assign bus.wb_ready = (state == IDLE);
  assign accept       = bus.wb_valid & bus.wb_ready;
  assign lm_go        = bus.wb_lm & (bus.wb_mask != 8'd0);
  // An LM with an empty mask degenerates to a PC-only update.
  assign single_wr    = bus.wb_wr_en & ~bus.wb_lm;
  assign mask_clr     = mask & (mask - 8'd1);
  assign wb_mask_clr  = bus.wb_mask & (bus.wb_mask - 8'd1);

  // Sequencer state, read issue, and registered register-file write ports.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      mask          <= 8'd0;
      base          <= '0;
      offset        <= '0;
      tag           <= 3'd0;
      pend          <= 1'b0;
      pend_tag      <= 3'd0;
      bus.mem_rd_en <= 1'b0;
      bus.mem_addr  <= '0;
      bus.A3        <= 3'd0;
      bus.RF3       <= '0;
      bus.rf3_wr_en <= 1'b0;
      bus.RF4       <= '0;
      bus.rf4_wr_en <= 1'b0;
    end else begin
      bus.rf4_wr_en <= 1'b0;

      // A read seen this cycle has its data next cycle; write it the cycle after.
      pend     <= bus.mem_rd_en;
      pend_tag <= tag;
      if (pend) begin
        bus.rf3_wr_en <= 1'b1;
        bus.A3        <= pend_tag;
        bus.RF3       <= bus.mem_rdata;
      end else begin
        bus.rf3_wr_en <= 1'b0;
        bus.A3        <= 3'd0;
      end

      case (state)
        IDLE: begin
          bus.mem_rd_en <= 1'b0;
          if (accept) begin
            bus.RF4 <= bus.wb_pc;
            if (lm_go) begin
              // First read goes out with the accept, so offset continues at 1.
              bus.rf4_wr_en <= bus.wb_pc_en;
              bus.mem_rd_en <= 1'b1;
              bus.mem_addr  <= bus.wb_base;
              tag           <= low_idx(bus.wb_mask);
              base          <= bus.wb_base;
              offset        <= DATA_W'(1);
              mask          <= wb_mask_clr;
              state         <= (wb_mask_clr == 8'd0) ? LM_DRAIN : LM_ISSUE;
            end else begin
              // An rf3 write to R7 wins over the PC port.
              bus.rf3_wr_en <= single_wr;
              bus.A3        <= single_wr ? bus.wb_dest : 3'd0;
              bus.RF3       <= bus.wb_data;
              bus.rf4_wr_en <= bus.wb_pc_en & ~(single_wr & (bus.wb_dest == 3'd7));
            end
          end
        end
        LM_ISSUE: begin
          bus.mem_rd_en <= 1'b1;
          bus.mem_addr  <= base + offset;
          tag           <= low_idx(mask);
          mask          <= mask_clr;
          offset        <= offset + DATA_W'(1);
          if (mask_clr == 8'd0) state <= LM_DRAIN;
        end
        LM_DRAIN: begin
          bus.mem_rd_en <= 1'b0;
          // Last read's data is being written at this edge.
          if (!bus.mem_rd_en && pend) state <= IDLE;
        end
        default: begin
          state         <= IDLE;
          bus.mem_rd_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_writeback_sequencer.sv
// Scoreboard bench for rf_writeback_sequencer: stimulus pushes expected
// rf3/rf4 writes, memory reads and per-cycle ready values; a negedge monitor
// pops and compares whatever the DUT presents.
module tb_rf_writeback_sequencer;

  logic clk;
  logic reset;
  int   cyc;
  bit   done;

  rf_writeback_sequencer_if #(.DATA_W(16)) bus ();

  rf_writeback_sequencer #(.DATA_W(16), .MEM_LAT(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          cyc;
    logic [2:0]  a;
    logic [15:0] d;
  } exp_t;

  exp_t q3[$];
  exp_t q4[$];
  exp_t qm[$];
  bit   exp_ready[int];
  bit   exp_zero[int];

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Data memory: returns addr ^ 0xA5A5 one cycle after the read strobe.
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rdata <= bus.mem_addr ^ 16'hA5A5;
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (cyc >= 1) begin
      if (bus.rf3_wr_en === 1'b1) begin
        total++;
        if (q3.size() == 0) begin
          bad++;
          $display("FAIL rf3_extra: cyc=%0d A3=%0d RF3=%h, required no write", cyc, bus.A3, bus.RF3);
        end else begin
          e = q3.pop_front();
          if (e.cyc != cyc || e.a !== bus.A3 || e.d !== bus.RF3) begin
            bad++;
            $display("FAIL rf3_write: got cyc=%0d A3=%0d RF3=%h, required cyc=%0d A3=%0d RF3=%h",
                     cyc, bus.A3, bus.RF3, e.cyc, e.a, e.d);
          end
        end
      end else begin
        total++;
        if (bus.rf3_wr_en !== 1'b0 || bus.A3 !== 3'd0) begin
          bad++;
          $display("FAIL a3_idle: cyc=%0d rf3_wr_en=%b A3=%0d, required 0/0", cyc, bus.rf3_wr_en, bus.A3);
        end
      end

      if (bus.rf4_wr_en === 1'b1) begin
        total++;
        if (q4.size() == 0) begin
          bad++;
          $display("FAIL rf4_extra: cyc=%0d RF4=%h, required no write", cyc, bus.RF4);
        end else begin
          e = q4.pop_front();
          if (e.cyc != cyc || e.d !== bus.RF4) begin
            bad++;
            $display("FAIL rf4_write: got cyc=%0d RF4=%h, required cyc=%0d RF4=%h", cyc, bus.RF4, e.cyc, e.d);
          end
        end
      end

      if (bus.mem_rd_en === 1'b1) begin
        total++;
        if (qm.size() == 0) begin
          bad++;
          $display("FAIL mem_extra: cyc=%0d addr=%h, required no read", cyc, bus.mem_addr);
        end else begin
          e = qm.pop_front();
          if (e.cyc != cyc || e.d !== bus.mem_addr) begin
            bad++;
            $display("FAIL mem_read: got cyc=%0d addr=%h, required cyc=%0d addr=%h", cyc, bus.mem_addr, e.cyc, e.d);
          end
        end
      end

      if (exp_ready.exists(cyc)) begin
        total++;
        if (bus.wb_ready !== exp_ready[cyc]) begin
          bad++;
          $display("FAIL wb_ready: cyc=%0d got %b, required %b", cyc, bus.wb_ready, exp_ready[cyc]);
        end
      end

      if (exp_zero.exists(cyc)) begin
        total++;
        if (bus.rf3_wr_en !== 1'b0 || bus.rf4_wr_en !== 1'b0 || bus.mem_rd_en !== 1'b0 ||
            bus.A3 !== 3'd0 || bus.RF3 !== 16'h0 || bus.RF4 !== 16'h0 ||
            bus.mem_addr !== 16'h0 || bus.wb_ready !== 1'b1) begin
          bad++;
          $display("FAIL reset_state: cyc=%0d en3/4/m=%b%b%b A3=%0d RF3=%h RF4=%h addr=%h ready=%b, required all 0 ready=1",
                   cyc, bus.rf3_wr_en, bus.rf4_wr_en, bus.mem_rd_en, bus.A3, bus.RF3, bus.RF4,
                   bus.mem_addr, bus.wb_ready);
        end
      end
    end

    if (done) begin
      total++;
      if (q3.size() != 0) begin
        bad++;
        $display("FAIL rf3_missing: %0d writes outstanding, required 0", q3.size());
      end
      total++;
      if (q4.size() != 0) begin
        bad++;
        $display("FAIL rf4_missing: %0d writes outstanding, required 0", q4.size());
      end
      total++;
      if (qm.size() != 0) begin
        bad++;
        $display("FAIL mem_missing: %0d reads outstanding, required 0", qm.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  // Offer one transaction at the coming edge and record what must follow.
  task automatic send(input bit lm, input bit wr, input logic [2:0] dest, input logic [15:0] data,
                      input logic [7:0] mask, input logic [15:0] base,
                      input bit pce, input logic [15:0] pc);
    int          a;
    int          k;
    int          n;
    bit          wr_eff;
    logic [15:0] addr;
    bus.wb_lm    = lm;
    bus.wb_wr_en = wr;
    bus.wb_dest  = dest;
    bus.wb_data  = data;
    bus.wb_mask  = mask;
    bus.wb_base  = base;
    bus.wb_pc_en = pce;
    bus.wb_pc    = pc;
    bus.wb_valid = 1'b1;
    exp_ready[cyc] = 1'b1;
    @(posedge clk);
    #1;
    a = cyc;
    bus.wb_valid = 1'b0;
    if (lm && mask != 8'd0) begin
      if (pce) q4.push_back('{a, 3'd0, pc});
      k = 0;
      for (int i = 0; i < 8; i++) begin
        if (mask[i]) begin
          addr = base + 16'(k);
          qm.push_back('{a + k, 3'd0, addr});
          q3.push_back('{a + k + 2, 3'(i), addr ^ 16'hA5A5});
          k++;
        end
      end
      n = k;
      for (int j = 0; j <= n; j++) exp_ready[a + j] = 1'b0;
      exp_ready[a + n + 1] = 1'b1;
      repeat (n + 1) begin
        @(posedge clk);
        #1;
      end
    end else begin
      wr_eff = wr && !lm;
      if (wr_eff) q3.push_back('{a, dest, data});
      if (pce && !(wr_eff && dest == 3'd7)) q4.push_back('{a, 3'd0, pc});
      exp_ready[a] = 1'b1;
    end
  endtask

  initial begin
    int a;
    done          = 1'b0;
    reset         = 1'b0;
    bus.wb_valid  = 1'b1;
    bus.wb_lm     = 1'b0;
    bus.wb_wr_en  = 1'b1;
    bus.wb_dest   = 3'd2;
    bus.wb_data   = 16'hDEAD;
    bus.wb_mask   = 8'h00;
    bus.wb_base   = 16'h0;
    bus.wb_pc_en  = 1'b1;
    bus.wb_pc     = 16'h5555;
    bus.mem_rdata = 16'h0;
    exp_zero[1] = 1'b1;
    exp_zero[2] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset        = 1'b1;
    bus.wb_valid = 1'b0;
    @(posedge clk);
    #1;

    // Single write with PC update, then four back-to-back singles.
    send(1'b0, 1'b1, 3'd3, 16'hBEEF, 8'h00, 16'h0, 1'b1, 16'h0042);
    send(1'b0, 1'b1, 3'd1, 16'h1111, 8'h00, 16'h0, 1'b0, 16'h0);
    send(1'b0, 1'b1, 3'd2, 16'h2222, 8'h00, 16'h0, 1'b0, 16'h0);
    send(1'b0, 1'b1, 3'd3, 16'h3333, 8'h00, 16'h0, 1'b0, 16'h0);
    send(1'b0, 1'b1, 3'd4, 16'h4444, 8'h00, 16'h0, 1'b0, 16'h0);
    // R7 through rf3 beats the PC port.
    send(1'b0, 1'b1, 3'd7, 16'h1234, 8'h00, 16'h0, 1'b1, 16'h0077);
    // PC-only single; wb_dest ignored without wb_wr_en.
    send(1'b0, 1'b0, 3'd7, 16'hAAAA, 8'h00, 16'h0, 1'b1, 16'h0099);
    @(posedge clk);
    #1;

    // LM R0,R2,R5,R7 from 0x0100 with PC update.
    send(1'b1, 1'b0, 3'd0, 16'h0, 8'b1010_0101, 16'h0100, 1'b1, 16'h0200);
    // LM all registers across the address wrap.
    send(1'b1, 1'b0, 3'd0, 16'h0, 8'hFF, 16'hFFFE, 1'b0, 16'h0);
    // Single R6 right after an LM.
    send(1'b0, 1'b1, 3'd6, 16'h6666, 8'h00, 16'h0, 1'b0, 16'h0);
    // LM with empty mask: PC only, wb_wr_en ignored.
    send(1'b1, 1'b1, 3'd4, 16'hFACE, 8'h00, 16'h0300, 1'b1, 16'h0123);
    // Single-register LM.
    send(1'b1, 1'b0, 3'd0, 16'h0, 8'b0100_0000, 16'h0040, 1'b0, 16'h0);
    @(posedge clk);
    #1;

    // Reset in spec cycle 3 of a full LM.
    bus.wb_lm    = 1'b1;
    bus.wb_wr_en = 1'b0;
    bus.wb_mask  = 8'hFF;
    bus.wb_base  = 16'h0300;
    bus.wb_pc_en = 1'b0;
    bus.wb_valid = 1'b1;
    exp_ready[cyc] = 1'b1;
    @(posedge clk);
    #1;
    a = cyc;
    bus.wb_valid = 1'b0;
    qm.push_back('{a,     3'd0, 16'h0300});
    qm.push_back('{a + 1, 3'd0, 16'h0301});
    qm.push_back('{a + 2, 3'd0, 16'h0302});
    q3.push_back('{a + 2, 3'd0, 16'h0300 ^ 16'hA5A5});
    exp_ready[a]     = 1'b0;
    exp_ready[a + 1] = 1'b0;
    exp_ready[a + 2] = 1'b0;
    exp_zero[a + 3]  = 1'b1;
    exp_zero[a + 4]  = 1'b1;
    exp_ready[a + 5] = 1'b1;
    exp_ready[a + 8] = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    done = 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach summary, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rf_writeback_sequencer.md
Name: rf_writeback_sequencer

Overview:
- Write-side driver of the 8x16 register file.
- Accepts writeback transactions from the pipeline's last stage through a valid/ready handshake and drives the register file write port (A3, RF3, rf3_wr_en) and its R7/PC port (RF4, rf4_wr_en).
- Single-register writes pass through with one cycle of latency.
- Load-multiple (LM) transactions are serialised: the block issues one data-memory read per selected register and writes each returned word to its register, one per cycle.

Parameters:
- DATA_W, 16, register/data/address width.
- MEM_LAT, 1, data-memory read latency in cycles. Only the value 1 is supported; any other value is a configuration error.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- wb_valid  in  1  transaction offered.
- wb_ready  out  1  sequencer can accept a transaction.
- wb_lm  in  1  1 = load-multiple, 0 = single write.
- wb_wr_en  in  1  single write requested; ignored when wb_lm=1.
- wb_dest  in  3  single-write destination register.
- wb_data  in  DATA_W  single-write data.
- wb_mask  in  8  LM register select; bit i selects Ri.
- wb_base  in  DATA_W  LM start memory address.
- wb_pc_en  in  1  PC (R7) update requested.
- wb_pc  in  DATA_W  new PC value.
- mem_rd_en  out  1  data-memory read strobe.
- mem_addr  out  DATA_W  data-memory read address.
- mem_rdata  in  DATA_W  read data, valid MEM_LAT cycles after mem_rd_en.
- A3  out  3  register-file write address.
- RF3  out  DATA_W  register-file write data.
- rf3_wr_en  out  1  register-file write enable.
- RF4  out  DATA_W  PC value to R7.
- rf4_wr_en  out  1  PC write enable.

Behaviour:
- All outputs are registered except wb_ready, which is (state==IDLE).
- Reset (reset=0 at a clk edge) forces:
  - state=IDLE;
  - rf3_wr_en=0, rf4_wr_en=0, mem_rd_en=0;
  - A3=0, RF3=0, RF4=0, mem_addr=0;
  - internal mask/offset/tag cleared.
- Reset mid-LM abandons the remaining writes; no further write is issued after reset.
- Whenever rf3_wr_en=0, A3 is driven to 0.
- Accept occurs at an edge where wb_valid & wb_ready.
- States: IDLE, LM_ISSUE, LM_DRAIN.
- IDLE, single write (wb_lm=0):
  - Next cycle: rf3_wr_en=wb_wr_en, A3=wb_dest, RF3=wb_data.
  - Next cycle: rf4_wr_en=wb_pc_en & !(wb_wr_en & wb_dest==7), RF4=wb_pc.
  - A write to R7 through rf3 takes priority over the PC update.
  - State stays IDLE, so back-to-back accepts give one write per cycle.
- IDLE, LM with wb_mask==0:
  - Behaves as a single write with wb_wr_en forced to 0; only the PC update is applied.
- IDLE, LM with wb_mask!=0:
  - Latch the mask and set offset=0.
  - Next cycle: rf4_wr_en=wb_pc_en, RF4=wb_pc.
  - Next cycle: issue the first read (see LM_ISSUE).
  - Go to LM_ISSUE.
- LM_ISSUE, each cycle:
  - mem_rd_en=1, mem_addr=base+offset, tag=index of the lowest set mask bit (ascending, R0 first).
  - Clear that bit and increment offset.
  - Addresses wrap modulo 2^DATA_W.
  - When the cleared mask becomes 0, go to LM_DRAIN after this issue.
- Read-data pipeline:
  - The data for a read issued in cycle C arrives in C+1.
  - In C+2: rf3_wr_en=1, A3=tag(C), RF3=mem_rdata.
  - Reads and writes overlap, giving one write per cycle.
- LM_DRAIN:
  - mem_rd_en=0.
  - Wait until the last write has been registered, then go to IDLE.
  - For N selected registers accepted at edge E0: reads occur in cycles 1..N, writes in cycles 3..N+2, and wb_ready=1 again from cycle N+2.
- rf4_wr_en is asserted only in the cycle immediately after accept and never coincides with an LM rf3 write.
- wb_valid while wb_ready=0 is ignored; the upstream stage must hold the transaction.

Test Plan:
- Reset: hold reset=0 for 2 cycles with wb_valid=1 -> all outputs 0, wb_ready=1, no writes.
- Single write: wb_dest=3, wb_data=0xBEEF, wb_pc_en=1, wb_pc=0x0042 -> next cycle rf3_wr_en=1, A3=3, RF3=0xBEEF, rf4_wr_en=1, RF4=0x0042. Then 4 back-to-back accepts (R1..R4) -> 4 consecutive write cycles, wb_ready stays 1.
- R7 conflict: wb_dest=7, wb_data=0x1234, wb_pc_en=1 -> rf3_wr_en=1, A3=7, RF3=0x1234, rf4_wr_en=0.
- LM: mask=0b10100101, base=0x0100, memory returns addr^0xA5A5 -> reads 0x0100..0x0103 in cycles 1-4; writes R0,R2,R5,R7 in cycles 3-6 with matching data; wb_ready low in cycles 1-5, high in cycle 6.
- LM edge cases:
  - mask=0xFF, base=0xFFFE -> addresses 0xFFFE,0xFFFF,0x0000..0x0005.
  - mask=0 -> PC update only, no mem_rd_en.
- Reset mid-LM: mask=0xFF, reset=0 in cycle 3 -> no rf3_wr_en after reset, state IDLE, wb_ready=1 once reset is released.
